// File: rtl/mac_adder_sched_if.sv
`timescale 1ns/1ps
// Request/response bundle between the two MAC8 requesters and the adder scheduler.
// Bit/field i of every vector belongs to requester i.
interface mac_adder_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [23:0] req_x;
  logic [23:0] req_y;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [23:0] rsp_data;

  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mac_adder_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler for two requesters sharing one external 3-operand 12-bit adder,
// with a single operand stage, per-requester accumulators and one-deep response buffers.
module mac_adder_sched #(
  parameter logic [11:0] ACC_INIT = 12'h000
) (
  input  logic                clk,
  input  logic                rst,
  mac_adder_sched_if.slave    req_if,
  output logic [11:0]         add_a_o,
  output logic [11:0]         add_b_o,
  output logic [11:0]         add_c_o,
  input  logic [11:0]         add_sum_i,
  output logic [23:0]         acc_o,
  output logic                busy_o
);
  typedef enum logic [1:0] {
    OP_SUM   = 2'b00,
    OP_ACC   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  logic             stage_v_q,   stage_v_d;
  logic             stage_id_q,  stage_id_d;
  op_e              stage_op_q,  stage_op_d;
  logic [11:0]      add_a_q,     add_a_d;
  logic [11:0]      add_b_q,     add_b_d;
  logic [11:0]      add_c_q,     add_c_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0][11:0] rsp_data_q,  rsp_data_d;
  logic [1:0][11:0] acc_q,       acc_d;
  logic             last_q,      last_d;

  logic [1:0]       busy_s;
  logic [1:0]       elig_s;
  logic [1:0]       grant_s;
  logic [1:0]       ready_s;
  logic             xfer_s;
  logic             xfer_id_s;
  op_e              sel_op_s;
  logic [11:0]      sel_x_s;
  logic [11:0]      sel_y_s;

  // Eligibility and grant: a lone eligible requester wins, a tie goes to the one not granted last.
  always_comb begin
    busy_s[0]  = (stage_v_q & ~stage_id_q) | rsp_valid_q[0];
    busy_s[1]  = (stage_v_q &  stage_id_q) | rsp_valid_q[1];
    elig_s     = req_if.req_valid & ~busy_s;
    grant_s[0] = elig_s[0] & (~elig_s[1] | last_q);
    grant_s[1] = elig_s[1] & (~elig_s[0] | ~last_q);
    if (rst) begin
      ready_s = 2'b00;
    end else begin
      ready_s = grant_s;
    end
    xfer_s    = |ready_s;
    xfer_id_s = ready_s[1];
  end

  // Field selection for the granted requester.
  always_comb begin
    if (xfer_id_s) begin
      sel_op_s = op_e'(req_if.req_op[3:2]);
      sel_x_s  = req_if.req_x[23:12];
      sel_y_s  = req_if.req_y[23:12];
    end else begin
      sel_op_s = op_e'(req_if.req_op[1:0]);
      sel_x_s  = req_if.req_x[11:0];
      sel_y_s  = req_if.req_y[11:0];
    end
  end

  // Next state: load the stage on a transfer, capture the adder result while the stage drains.
  always_comb begin
    stage_v_d   = xfer_s;
    stage_id_d  = stage_id_q;
    stage_op_d  = stage_op_q;
    add_a_d     = 12'h000;
    add_b_d     = 12'h000;
    add_c_d     = 12'h000;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q & ~req_if.rsp_ready;
    rsp_data_d  = rsp_data_q;
    acc_d       = acc_q;

    if (xfer_s) begin
      stage_id_d = xfer_id_s;
      stage_op_d = sel_op_s;
      last_d     = xfer_id_s;
      // acc of the granted requester is final here: its previous op has already been captured.
      case (sel_op_s)
        OP_SUM: begin
          add_a_d = sel_x_s;
          add_b_d = sel_y_s;
        end
        OP_ACC: begin
          add_a_d = sel_x_s;
          add_b_d = sel_y_s;
          add_c_d = acc_q[xfer_id_s];
        end
        OP_LOAD: begin
          add_a_d = sel_x_s;
        end
        OP_CLEAR: begin
          add_a_d = 12'h000;
        end
        default: begin
          add_a_d = 12'h000;
        end
      endcase
    end else begin
      stage_id_d = stage_id_q;
    end

    if (stage_v_q) begin
      rsp_valid_d[stage_id_q] = 1'b1;
      rsp_data_d[stage_id_q]  = add_sum_i;
      if (stage_op_q != OP_SUM) begin
        acc_d[stage_id_q] = add_sum_i;
      end else begin
        acc_d[stage_id_q] = acc_q[stage_id_q];
      end
    end else begin
      rsp_data_d = rsp_data_q;
    end
  end

  // State registers with synchronous reset; the last-granted pointer starts at requester 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_v_q   <= 1'b0;
      stage_id_q  <= 1'b0;
      stage_op_q  <= OP_SUM;
      add_a_q     <= 12'h000;
      add_b_q     <= 12'h000;
      add_c_q     <= 12'h000;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= {12'h000, 12'h000};
      acc_q       <= {ACC_INIT, ACC_INIT};
      last_q      <= 1'b1;
    end else begin
      stage_v_q   <= stage_v_d;
      stage_id_q  <= stage_id_d;
      stage_op_q  <= stage_op_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_c_q     <= add_c_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      acc_q       <= acc_d;
      last_q      <= last_d;
    end
  end

  assign req_if.req_ready = ready_s;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = rsp_data_q;
  assign add_a_o          = add_a_q;
  assign add_b_o          = add_b_q;
  assign add_c_o          = add_c_q;
  assign acc_o            = acc_q;
  assign busy_o           = stage_v_q | (|rsp_valid_q);
endmodule
